// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux_41 scan sequencer: state encoding, channel
// geometry and the dwell counter width helper.
package mux_scan_defs;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NCH - 1);

  // A dwell of 1 still needs a one-bit counter so the port widths stay legal.
  function automatic int cnt_w(input int dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_dwell_counter.sv
// Counts the cycles a channel is held; last marks the final dwell cycle so the
// sequencer knows when the mux output has settled and can be captured.
module dwell_counter
  import mux_scan_defs::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic last
);

  localparam int CW = cnt_w(DWELL);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= last ? '0 : r_cnt + CW'(1);
    end
  end

  assign last = (r_cnt == CNT_LAST);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sequencer around mux_41: steps sel through all channels, holds each for DWELL
// cycles, captures y per channel and publishes a whole-frame snapshot.
module mux_scan_ctrl
  import mux_scan_defs::*;
#(
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             y,
  output logic [SEL_W-1:0] sel,
  output logic [NCH-1:0]   sample,
  output logic             sample_valid,
  output logic             busy
);

  state_t             r_state;
  logic [SEL_W-1:0]   r_sel;
  logic [NCH-2:0]     r_shadow;
  logic [NCH-1:0]     r_sample;
  logic               r_valid;

  state_t             w_state_nxt;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic [NCH-2:0]     w_shadow_nxt;
  logic [NCH-1:0]     w_sample_nxt;
  logic               w_valid_nxt;
  logic               w_last;
  logic               w_en;
  logic               w_clr;
  logic               w_frame_end;

  assign w_en        = (r_state == ST_SCAN);
  assign w_clr       = (r_state == ST_IDLE) && start;
  assign w_frame_end = w_en && w_last && (r_sel == SEL_LAST);

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .en   (w_en),
    .clr  (w_clr),
    .last (w_last)
  );

  // State and all outputs are registered together so nothing glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_shadow <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_shadow <= w_shadow_nxt;
      r_sample <= w_sample_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  // start is only honoured in IDLE; at frame end continuous alone decides.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_SCAN;
      ST_SCAN: if (w_frame_end && !continuous) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sel_nxt    = r_sel;
    w_shadow_nxt = r_shadow;
    w_sample_nxt = r_sample;
    w_valid_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_sel_nxt = '0;
      end
      ST_SCAN: begin
        if (w_last) begin
          if (r_sel != SEL_LAST) begin
            w_shadow_nxt[r_sel] = y;
            w_sel_nxt           = r_sel + SEL_W'(1);
          end else begin
            // Last channel goes straight into the snapshot, never via shadow.
            w_sample_nxt = {y, r_shadow};
            w_valid_nxt  = 1'b1;
            w_sel_nxt    = '0;
          end
        end
      end
      default: w_sel_nxt = '0;
    endcase
  end

  assign sel          = r_sel;
  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign busy         = (r_state == ST_SCAN);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: three instances (DWELL 4, 1, 2) each fed by
// a behavioural 4:1 mux built from a per-instance data word {d,c,b,a}.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start  [3];
  logic       cont   [3];
  logic       y      [3];
  logic [1:0] sel    [3];
  logic [3:0] sample [3];
  logic       valid  [3];
  logic       busy   [3];
  logic [3:0] data   [3];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign y[0] = data[0][sel[0]];
  assign y[1] = data[1][sel[1]];
  assign y[2] = data[2][sel[2]];

  mux_scan_ctrl #(.DWELL(4)) u_a (
    .clk (clk), .rst (rst), .start (start[0]), .continuous (cont[0]), .y (y[0]),
    .sel (sel[0]), .sample (sample[0]), .sample_valid (valid[0]), .busy (busy[0])
  );

  mux_scan_ctrl #(.DWELL(1)) u_b (
    .clk (clk), .rst (rst), .start (start[1]), .continuous (cont[1]), .y (y[1]),
    .sel (sel[1]), .sample (sample[1]), .sample_valid (valid[1]), .busy (busy[1])
  );

  mux_scan_ctrl #(.DWELL(2)) u_c (
    .clk (clk), .rst (rst), .start (start[2]), .continuous (cont[2]), .y (y[2]),
    .sel (sel[2]), .sample (sample[2]), .sample_valid (valid[2]), .busy (busy[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_u%0d_sel", tag, k), sel[k], 0);
      check($sformatf("%s_u%0d_sample", tag, k), sample[k], 0);
      check($sformatf("%s_u%0d_valid", tag, k), valid[k], 0);
      check($sformatf("%s_u%0d_busy", tag, k), busy[k], 0);
    end
  endtask

  // One non-continuous frame on instance k. poke: cycle at which a stray start
  // is seen while busy (0 = none). flip: cycle after which input a is toggled.
  task automatic run_frame(input int k, input int d, input logic [3:0] prev,
                           input logic [3:0] exp, input int poke, input int flip);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
    check($sformatf("u%0d_start_busy", k), busy[k], 1);
    check($sformatf("u%0d_start_sel", k), sel[k], 0);
    check($sformatf("u%0d_start_valid", k), valid[k], 0);
    for (int i = 1; i <= 4 * d; i++) begin
      tick();
      check($sformatf("u%0d_sel_c%0d", k, i), sel[k], (i % (4 * d)) / d);
      check($sformatf("u%0d_valid_c%0d", k, i), valid[k], (i == 4 * d));
      check($sformatf("u%0d_busy_c%0d", k, i), busy[k], (i < 4 * d));
      check($sformatf("u%0d_sample_c%0d", k, i), sample[k], (i == 4 * d) ? exp : prev);
      start[k] = (i == poke - 1);
      if (i == flip) data[k][0] = ~data[k][0];
    end
    tick();
    check($sformatf("u%0d_post_valid", k), valid[k], 0);
    check($sformatf("u%0d_post_busy", k), busy[k], 0);
    check($sformatf("u%0d_post_sample", k), sample[k], exp);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      cont[k]  = 1'b0;
    end
    data[0] = 4'b1010;
    data[1] = 4'b0110;
    data[2] = 4'b0101;
    repeat (2) tick();
    check_idle_reset("reset");
    rst = 1'b0;
    tick();

    // DWELL=4 single frame, then a stray start at cycle 5 that must be ignored
    run_frame(0, 4, 4'b0000, 4'b1010, 0, 0);
    run_frame(0, 4, 4'b1010, 4'b1010, 5, 0);

    // a toggled after channel 0 is captured: old a this frame, new a next frame
    run_frame(0, 4, 4'b1010, 4'b1010, 0, 5);
    run_frame(0, 4, 4'b1010, 4'b1011, 0, 0);

    // DWELL=1: sel advances every cycle, valid 4 cycles after start
    run_frame(1, 1, 4'b0000, 4'b0110, 0, 0);

    // DWELL=2 continuous: pulses every 8 cycles; data changes after the first
    // pulse; continuous dropped in frame 3; start coincides with final frame end
    cont[2]  = 1'b1;
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    check("u2_cont_start_busy", busy[2], 1);
    for (int i = 1; i <= 24; i++) begin
      tick();
      check($sformatf("u2_cont_sel_c%0d", i), sel[2], (i % 8) / 2);
      check($sformatf("u2_cont_valid_c%0d", i), valid[2], (i % 8 == 0));
      check($sformatf("u2_cont_busy_c%0d", i), busy[2], (i < 24));
      check($sformatf("u2_cont_sample_c%0d", i), sample[2],
            (i < 8) ? 4'b0000 : (i < 16) ? 4'b0101 : 4'b1111);
      if (i == 8) data[2] = 4'b1111;
      if (i == 18) cont[2] = 1'b0;
      start[2] = (i == 23);
    end
    tick();
    check("u2_cont_end_busy", busy[2], 0);
    check("u2_cont_end_valid", valid[2], 0);
    check("u2_cont_end_sel", sel[2], 0);

    // Reset held for 3 cycles in the middle of a DWELL=4 frame
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (5) tick();
    check("u0_midframe_busy", busy[0], 1);
    check("u0_midframe_sel", sel[0], 1);
    rst = 1'b1;
    repeat (3) tick();
    check_idle_reset("midrst");
    rst = 1'b0;
    tick();
    check("u0_after_rst_busy", busy[0], 0);
    check("u0_after_rst_sample", sample[0], 0);
    check("u0_after_rst_sel", sel[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
